// File: rtl/AHB_package.sv
// Shared AHB encodings and arbiter state type for the slave_7 arbiter.
// burst_len() maps HBURST to the number of beats in a defined-length burst.
package AHB_package;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        SINGLE = 3'd0,
        INCR   = 3'd1,
        WRAP4  = 3'd2,
        INCR4  = 3'd3,
        WRAP8  = 3'd4,
        INCR8  = 3'd5,
        WRAP16 = 3'd6,
        INCR16 = 3'd7
    } hburst_t;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_BURST  = 2'd1,
        ARB_LOCKED = 2'd2
    } arb_state_t;

    localparam int BEAT_W = 5;

    // INCR is undefined-length; callers handle it separately, here it reads as 1.
    function automatic logic [BEAT_W-1:0] burst_len(input hburst_t b);
        case (b)
            WRAP4, INCR4:   return 5'd4;
            WRAP8, INCR8:   return 5'd8;
            WRAP16, INCR16: return 5'd16;
            default:        return 5'd1;
        endcase
    endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// Combinational rotating-priority picker: first requester at or after i_ptr.
// With AHB_ARB_FIXED_PRIO_EN defined the lowest requesting index wins and i_ptr is ignored.
module ahb_rr_picker #(
    parameter int CHANNEL_NUM = 2,
    parameter int IDX_W       = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1
) (
    input  logic [CHANNEL_NUM-1:0] i_req,
    input  logic [IDX_W-1:0]       i_ptr,
    output logic [CHANNEL_NUM-1:0] o_grant,
    output logic [IDX_W-1:0]       o_winner,
    output logic                   o_valid
);

    int w_idx;

    always_comb begin
        o_valid  = 1'b0;
        o_winner = '0;
        w_idx    = 0;
        for (int k = 0; k < CHANNEL_NUM; k++) begin
`ifdef AHB_ARB_FIXED_PRIO_EN
            w_idx = k;
`else
            w_idx = (int'(i_ptr) + k) % CHANNEL_NUM;
`endif
            if (!o_valid && i_req[w_idx]) begin
                o_valid  = 1'b1;
                o_winner = IDX_W'(w_idx);
            end
        end
    end

    assign o_grant = o_valid ? (CHANNEL_NUM'(1) << o_winner) : '0;

endmodule

// File: rtl/ahb_arbiter_slave_7.sv
// Per-slave AHB arbiter for slave_7: address-phase owner select, data-phase select, stalls.
// Round-robin by default; define AHB_ARB_FIXED_PRIO_EN for lowest-index-wins arbitration.
module ahb_arbiter_slave_7
    import AHB_package::*;
#(
    parameter int CHANNEL_NUM = 2
) (
    input  logic                     HCLK,
    input  logic                     HRESET,
    input  logic [CHANNEL_NUM-1:0]   hreq,
    input  logic [CHANNEL_NUM*2-1:0] htrans,
    input  logic [CHANNEL_NUM*3-1:0] hburst,
    input  logic [CHANNEL_NUM-1:0]   hmastlock,
    input  logic                     hready,
    output logic [CHANNEL_NUM-1:0]   addr_sel,
    output logic [CHANNEL_NUM-1:0]   data_sel,
    output logic [CHANNEL_NUM-1:0]   wait_req
);

    localparam int IDX_W = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;

    arb_state_t             r_state;
    logic [IDX_W-1:0]       r_owner;
    logic [BEAT_W-1:0]      r_beat_cnt;
    logic                   r_incr_flag;
    logic [CHANNEL_NUM-1:0] r_addr_sel;
    logic [CHANNEL_NUM-1:0] r_data_sel;
    logic [IDX_W-1:0]       w_ptr;

    htrans_t                w_trans [CHANNEL_NUM];
    hburst_t                w_burst [CHANNEL_NUM];
    htrans_t                w_own_trans;
    hburst_t                w_own_burst;
    logic                   w_own_req;
    logic                   w_own_lock;
    logic [BEAT_W-1:0]      w_beat_next;
    logic                   w_incr_next;
    logic                   w_last_seq;
    logic                   w_end;
    logic                   w_release;
    logic [CHANNEL_NUM-1:0] w_pick_grant;
    logic [IDX_W-1:0]       w_pick_idx;
    logic                   w_pick_valid;

    for (genvar gi = 0; gi < CHANNEL_NUM; gi++) begin : g_chan
        assign w_trans[gi]  = htrans_t'(htrans[2*gi +: 2]);
        assign w_burst[gi]  = hburst_t'(hburst[3*gi +: 3]);
        assign wait_req[gi] = hreq[gi] & ~r_addr_sel[gi];
    end

    assign w_own_trans = w_trans[r_owner];
    assign w_own_burst = w_burst[r_owner];
    assign w_own_req   = hreq[r_owner];
    assign w_own_lock  = hmastlock[r_owner];

    // Beat tracking of the owner's transfer accepted on this edge, and the burst-end test.
    always_comb begin
        w_beat_next = r_beat_cnt;
        w_incr_next = r_incr_flag;
        w_last_seq  = 1'b0;
        case (w_own_trans)
            NONSEQ: begin
                if (w_own_burst == INCR) begin
                    w_incr_next = 1'b1;
                    w_beat_next = '0;
                end else begin
                    w_incr_next = 1'b0;
                    w_beat_next = burst_len(w_own_burst) - 5'd1;
                end
            end
            SEQ: begin
                w_last_seq = !r_incr_flag && (r_beat_cnt == 5'd1);
                if (r_beat_cnt != '0) w_beat_next = r_beat_cnt - 5'd1;
            end
            default: ;
        endcase
        w_end = (w_own_trans == IDLE) || !w_own_req ||
                ((w_own_trans == NONSEQ) && (w_own_burst == SINGLE)) || w_last_seq;
        w_release = (r_state == ARB_IDLE) ||
                    (((r_state == ARB_BURST) || !w_own_lock) && w_end);
    end

`ifdef AHB_ARB_FIXED_PRIO_EN
    assign w_ptr = '0;
`else
    logic [IDX_W-1:0] r_rr_ptr;
    assign w_ptr = r_rr_ptr;
`endif

    ahb_rr_picker #(
        .CHANNEL_NUM (CHANNEL_NUM),
        .IDX_W       (IDX_W)
    ) u_picker (
        .i_req    (hreq),
        .i_ptr    (w_ptr),
        .o_grant  (w_pick_grant),
        .o_winner (w_pick_idx),
        .o_valid  (w_pick_valid)
    );

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_state     <= ARB_IDLE;
            r_owner     <= '0;
            r_beat_cnt  <= '0;
            r_incr_flag <= 1'b0;
            r_addr_sel  <= '0;
            r_data_sel  <= '0;
`ifndef AHB_ARB_FIXED_PRIO_EN
            r_rr_ptr    <= '0;
`endif
        end else if (hready) begin
            r_data_sel <= r_addr_sel;
            if (r_state != ARB_IDLE) begin
                r_beat_cnt  <= w_beat_next;
                r_incr_flag <= w_incr_next;
            end
            if (w_release) begin
                if (w_pick_valid) begin
                    r_addr_sel  <= w_pick_grant;
                    r_owner     <= w_pick_idx;
                    r_state     <= hmastlock[w_pick_idx] ? ARB_LOCKED : ARB_BURST;
                    r_beat_cnt  <= '0;
                    r_incr_flag <= 1'b0;
`ifndef AHB_ARB_FIXED_PRIO_EN
                    r_rr_ptr    <= (w_pick_idx == IDX_W'(CHANNEL_NUM - 1)) ? '0
                                                                           : w_pick_idx + IDX_W'(1);
`endif
                end else begin
                    r_addr_sel <= '0;
                    r_state    <= ARB_IDLE;
                end
            end else if ((r_state == ARB_LOCKED) && !w_own_lock) begin
                // Lock dropped mid-burst: keep the owner but fall back to burst holding.
                r_state <= ARB_BURST;
            end
        end
    end

    assign addr_sel = r_addr_sel;
    assign data_sel = r_data_sel;

endmodule

// File: tb/tb_ahb_arbiter_slave_7.sv
// Scoreboard bench for ahb_arbiter_slave_7: directed scenarios plus random traffic,
// checked against a transaction-level model of ownership, bursts, locks and round-robin.
module tb_ahb_arbiter_slave_7;
    import AHB_package::*;

    logic       HCLK = 1'b0;
    logic       HRESET;
    logic [1:0] hreq;
    logic [3:0] htrans;
    logic [5:0] hburst;
    logic [1:0] hmastlock;
    logic       hready;
    logic [1:0] addr_sel;
    logic [1:0] data_sel;
    logic [1:0] wait_req;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [1:0] a;
        logic [1:0] d;
        logic [1:0] w;
        string      tag;
    } exp_t;
    exp_t q[$];

    // Reference model state: who owns the slave and how much of its burst remains.
    int         m_owner;
    int         m_left;
    int         m_rr;
    bit         m_locked;
    bit         m_incr;
    logic [1:0] m_addr;
    logic [1:0] m_data;

    ahb_arbiter_slave_7 #(.CHANNEL_NUM(2)) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .hreq      (hreq),
        .htrans    (htrans),
        .hburst    (hburst),
        .hmastlock (hmastlock),
        .hready    (hready),
        .addr_sel  (addr_sel),
        .data_sel  (data_sel),
        .wait_req  (wait_req)
    );

    always #5 HCLK = ~HCLK;

    function automatic void model_reset();
        m_owner  = -1;
        m_left   = 0;
        m_rr     = 0;
        m_locked = 0;
        m_incr   = 0;
        m_addr   = 2'b00;
        m_data   = 2'b00;
    endfunction

    function automatic int beats_of(hburst_t b);
        if (b == SINGLE) return 1;
        return 4 << ((int'(b) - 2) / 2);
    endfunction

    function automatic int pick(logic [1:0] r);
        for (int k = 0; k < 2; k++) begin
            int i;
            i = (m_rr + k) % 2;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    // Effect of one HCLK edge with the currently driven inputs.
    function automatic void model_edge();
        int      w;
        bit      rel;
        bit      last;
        htrans_t tr;
        hburst_t bu;
        if (HRESET) begin
            model_reset();
            return;
        end
        if (!hready) return;
        m_data = m_addr;
        rel    = 1'b1;
        if (m_owner >= 0) begin
            tr   = htrans_t'(htrans[2*m_owner +: 2]);
            bu   = hburst_t'(hburst[3*m_owner +: 3]);
            last = 1'b0;
            if (tr == NONSEQ) begin
                m_incr = (bu == INCR);
                m_left = (bu == INCR) ? 0 : beats_of(bu) - 1;
            end else if (tr == SEQ) begin
                last = !m_incr && (m_left == 1);
                if (m_left > 0) m_left--;
            end
            if (m_locked && hmastlock[m_owner]) begin
                rel = 1'b0;
            end else begin
                m_locked = 0;
                rel = (tr == IDLE) || !hreq[m_owner] || (tr == NONSEQ && bu == SINGLE) || last;
            end
        end
        if (rel) begin
            w = pick(hreq);
            if (w < 0) begin
                m_owner = -1;
                m_addr  = 2'b00;
            end else begin
                m_owner  = w;
                m_addr   = 2'b01 << w;
                m_locked = hmastlock[w];
                m_left   = 0;
                m_incr   = 0;
`ifndef AHB_ARB_FIXED_PRIO_EN
                m_rr     = (w + 1) % 2;
`endif
            end
        end
    endfunction

    // Drive one cycle of inputs, queue what the DUT must show before the coming edge.
    task automatic cyc(input logic [1:0] req, input htrans_t t1, input htrans_t t0,
                       input hburst_t b1, input hburst_t b0, input logic [1:0] lk,
                       input logic rdy, input string tag);
        exp_t e;
        hreq      = req;
        htrans    = {t1, t0};
        hburst    = {b1, b0};
        hmastlock = lk;
        hready    = rdy;
        e.a = m_addr;
        e.d = m_data;
        e.w = req & ~m_addr;
        e.tag = tag;
        q.push_back(e);
        model_edge();
        @(posedge HCLK);
        #1;
    endtask

    // Asynchronous reset asserted between edges with the current inputs left in place.
    task automatic do_reset(input string tag);
        exp_t e;
        HRESET = 1'b1;
        model_reset();
        e.a = 2'b00;
        e.d = 2'b00;
        e.w = hreq;
        e.tag = tag;
        q.push_back(e);
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge HCLK);
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (addr_sel !== e.a || data_sel !== e.d || wait_req !== e.w) begin
                    failures++;
                    $display("FAIL %s: addr_sel=%b data_sel=%b wait_req=%b, required %b %b %b",
                             e.tag, addr_sel, data_sel, wait_req, e.a, e.d, e.w);
                end else begin
                    $display("chk %s: addr_sel=%b data_sel=%b wait_req=%b",
                             e.tag, addr_sel, data_sel, wait_req);
                end
            end
        end
    end

    initial begin : stim
        htrans_t    rt [2];
        hburst_t    rb [2];
        logic [1:0] rq;
        logic [1:0] lk_r;
        int         r;
        HRESET    = 1'b1;
        hreq      = 2'b00;
        htrans    = '0;
        hburst    = '0;
        hmastlock = 2'b00;
        hready    = 1'b1;
        lk_r      = 2'b00;
        model_reset();
        @(posedge HCLK);
        #1;
        do_reset("reset_state");

        // Reset in the middle of an INCR4 burst, then a fresh grant one edge later.
        cyc(2'b01, IDLE, NONSEQ, SINGLE, INCR4, 2'b00, 1'b1, "rst_req");
        cyc(2'b01, IDLE, NONSEQ, SINGLE, INCR4, 2'b00, 1'b1, "rst_beat1");
        cyc(2'b01, IDLE, SEQ,    SINGLE, INCR4, 2'b00, 1'b1, "rst_beat2");
        do_reset("rst_async");
        cyc(2'b01, IDLE, NONSEQ, SINGLE, SINGLE, 2'b00, 1'b1, "rst_after");
        cyc(2'b00, IDLE, IDLE,   SINGLE, SINGLE, 2'b00, 1'b1, "rst_regrant");
        cyc(2'b00, IDLE, IDLE,   SINGLE, SINGLE, 2'b00, 1'b1, "idle");
        cyc(2'b00, IDLE, IDLE,   SINGLE, SINGLE, 2'b00, 1'b1, "idle");

        // Single transfer from master 0.
        cyc(2'b01, IDLE, NONSEQ, SINGLE, SINGLE, 2'b00, 1'b1, "single_req");
        cyc(2'b00, IDLE, IDLE,   SINGLE, SINGLE, 2'b00, 1'b1, "single_addr");
        cyc(2'b00, IDLE, IDLE,   SINGLE, SINGLE, 2'b00, 1'b1, "single_data");
        cyc(2'b00, IDLE, IDLE,   SINGLE, SINGLE, 2'b00, 1'b1, "single_done");

        // Both masters issue back-to-back SINGLEs.
        for (int i = 0; i < 6; i++)
            cyc(2'b11, NONSEQ, NONSEQ, SINGLE, SINGLE, 2'b00, 1'b1, "rr_contend");
        cyc(2'b00, IDLE, IDLE, SINGLE, SINGLE, 2'b00, 1'b1, "rr_drain");
        cyc(2'b00, IDLE, IDLE, SINGLE, SINGLE, 2'b00, 1'b1, "idle");

        // Master 1 INCR4 held against master 0, two wait states on beat 3.
        cyc(2'b10, NONSEQ, IDLE,   INCR4, SINGLE, 2'b00, 1'b1, "burst_req");
        cyc(2'b11, NONSEQ, NONSEQ, INCR4, SINGLE, 2'b00, 1'b1, "burst_b1");
        cyc(2'b11, SEQ,    NONSEQ, INCR4, SINGLE, 2'b00, 1'b1, "burst_b2");
        cyc(2'b11, SEQ,    NONSEQ, INCR4, SINGLE, 2'b00, 1'b0, "burst_b3_wait");
        cyc(2'b11, SEQ,    NONSEQ, INCR4, SINGLE, 2'b00, 1'b0, "burst_b3_wait");
        cyc(2'b11, SEQ,    NONSEQ, INCR4, SINGLE, 2'b00, 1'b1, "burst_b3");
        cyc(2'b11, SEQ,    NONSEQ, INCR4, SINGLE, 2'b00, 1'b1, "burst_b4");
        cyc(2'b01, IDLE,   NONSEQ, INCR4, SINGLE, 2'b00, 1'b1, "burst_switch");
        cyc(2'b00, IDLE,   IDLE,   INCR4, SINGLE, 2'b00, 1'b1, "idle");
        cyc(2'b00, IDLE,   IDLE,   INCR4, SINGLE, 2'b00, 1'b1, "idle");

        // Locked pair of SINGLEs from master 0 with master 1 waiting.
        cyc(2'b01, IDLE,   NONSEQ, SINGLE, SINGLE, 2'b01, 1'b1, "lock_req");
        cyc(2'b11, NONSEQ, NONSEQ, SINGLE, SINGLE, 2'b01, 1'b1, "lock_s1");
        cyc(2'b11, NONSEQ, NONSEQ, SINGLE, SINGLE, 2'b01, 1'b1, "lock_s2");
        cyc(2'b10, NONSEQ, IDLE,   SINGLE, SINGLE, 2'b00, 1'b1, "lock_drop");
        cyc(2'b10, NONSEQ, IDLE,   SINGLE, SINGLE, 2'b00, 1'b1, "lock_handover");
        cyc(2'b00, IDLE,   IDLE,   SINGLE, SINGLE, 2'b00, 1'b1, "idle");
        cyc(2'b00, IDLE,   IDLE,   SINGLE, SINGLE, 2'b00, 1'b1, "idle");

        // New request from master 1 during three wait states.
        for (int i = 0; i < 3; i++)
            cyc(2'b10, NONSEQ, IDLE, SINGLE, SINGLE, 2'b00, 1'b0, "wait_frozen");
        cyc(2'b10, NONSEQ, IDLE, SINGLE, SINGLE, 2'b00, 1'b1, "wait_release");
        cyc(2'b00, IDLE,   IDLE, SINGLE, SINGLE, 2'b00, 1'b1, "wait_granted");
        cyc(2'b00, IDLE,   IDLE, SINGLE, SINGLE, 2'b00, 1'b1, "idle");

        // Random traffic with occasional locks, stalls and resets.
        for (int n = 0; n < 600; n++) begin
            for (int m = 0; m < 2; m++) begin
                r = $urandom_range(0, 19);
                rt[m] = (r < 2) ? IDLE : (r < 5) ? BUSY : (r < 10) ? NONSEQ : SEQ;
                rq[m] = (rt[m] != IDLE) && ($urandom_range(0, 15) != 0);
                rb[m] = hburst_t'($urandom_range(0, 7));
                if ($urandom_range(0, 7) == 0) lk_r[m] = ~lk_r[m];
            end
            if ($urandom_range(0, 149) == 0) begin
                hreq = rq;
                do_reset("rnd_reset");
            end else begin
                cyc(rq, rt[1], rt[0], rb[1], rb[0], lk_r,
                    logic'($urandom_range(0, 4) != 0), "random");
            end
        end

        for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge HCLK);
        if (q.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d expected responses never compared, required 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
